mdu_iter: RTL and testbench
===========================

MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 64, datapath width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter EN_W, default 1, enabling the 32-bit word ops; SHALL be ignored when WIDTH=32.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port reset_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, request accepted on an edge where in_valid&&in_ready.
REQ-007 SHALL have port op, input, md_op_t, one of MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, MULW, DIVW, DIVUW, REMW, REMUW.
REQ-008 SHALL have ports a and b, input, WIDTH, operands rs1 and rs2.
REQ-009 SHALL have port flush, input, 1, synchronous abort.
REQ-010 SHALL have port out_valid, output, 1, result present.
REQ-011 SHALL have port out_ready, output consumer handshake, input, 1.
REQ-012 SHALL have port result, output, WIDTH, final value, stable while out_valid=1.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, FIX, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE.
- Accept SHALL latch op, a, b.
- Accept SHALL go to BUSY with cnt=0, or to DONE directly for special cases (REQ-019, REQ-020).
REQ-015 BUSY SHALL perform one radix-2 step per cycle.
- Multiply: shift-add on magnitudes.
- Divide: restoring division on magnitudes.
- Iteration count N=WIDTH, or 32 for W ops.
- Leave BUSY after the step with cnt=N-1.
REQ-016 FIX SHALL apply sign correction, select the hi/lo half, and register result; it SHALL last one cycle and lead to DONE.
REQ-017 out_valid SHALL be 1 only in DONE.
- DONE->IDLE on out_ready=1.
- Result SHALL hold while out_ready=0.
REQ-018 Normal-path latency SHALL be N+1 cycles from the accepting edge to out_valid=1.
REQ-019 Divide by zero SHALL complete in 1 cycle.
- Quotient: all ones.
- Remainder: dividend.
REQ-020 Signed overflow (dividend = most-negative, divisor = -1) SHALL complete in 1 cycle.
- Quotient: dividend.
- Remainder: 0.
REQ-021 Signedness SHALL be:
- MULH: signed x signed.
- MULHSU: signed x unsigned.
- MULHU, DIVU, REMU: unsigned.
- Remainder sign SHALL follow the dividend.
- Quotient SHALL truncate toward zero.
REQ-022 W ops SHALL use a[31:0] and b[31:0] and sign-extend the 32-bit result to WIDTH, including DIVUW/REMUW.
REQ-023 W ops SHALL be treated as unsupported when WIDTH=32 or EN_W=0.
- Unsupported and illegal op codes SHALL complete in 1 cycle with result 0.
REQ-024 flush=1 SHALL force IDLE at the next edge from any state, with out_valid=0.
- flush SHALL win over a simultaneous accept; the request is not taken.
- flush SHALL win over a simultaneous out_ready.
REQ-025 Operand inputs SHALL be ignored outside the accepting edge.

Reset
REQ-026 reset_n=0 SHALL asynchronously force state=IDLE, cnt=0, and all datapath registers to 0.
REQ-027 During reset, outputs SHALL be in_ready=0, out_valid=0, result=0.
REQ-028 in_ready SHALL rise the first cycle after reset_n deasserts.
REQ-029 Reset asserted mid-BUSY SHALL discard the operation; no out_valid SHALL follow.

Structure
REQ-030 md_op_t, MDU_WIDTH_DEFAULT and the FSM state typedef SHALL live in package common.
REQ-031 The per-iteration divide step (trial subtract, shift, quotient bit) SHALL be sub-module div_step.
- div_step SHALL be combinational and parametrised by WIDTH.
- The FSM, counter and multiply step SHALL remain in mdu_iter.

Verification
REQ-032 With WIDTH=64:
- Input: MUL a=3, b=-5.
- Required: result=0xFFFFFFFFFFFFFFF1.
- Required: out_valid exactly 65 cycles after accept.
REQ-033 Scenario: DIV a=-7, b=2 gives 0xFFFFFFFFFFFFFFFD; REM on the same operands gives 0xFFFFFFFFFFFFFFFF.
REQ-034 Scenario: special-case fast path.
- DIVU a=42, b=0 gives all ones.
- REM a=42, b=0 gives 42.
- DIV 0x8000000000000000 / -1 gives 0x8000000000000000.
- All three: out_valid 1 cycle after accept.
REQ-035 Scenario: word and high ops.
- MULW a=0x7FFFFFFF, b=2: result 0xFFFFFFFFFFFFFFFE, latency 33.
- MULHU a=b=all ones: result 0xFFFFFFFFFFFFFFFE.
REQ-036 Scenario: flush and held result.
- flush at BUSY cycle 10: IDLE next cycle, no out_valid, next request correct.
- out_ready held low 5 cycles in DONE: result stable, in_ready=0.
REQ-037 Scenario: reset_n pulsed low mid-BUSY: outputs 0 immediately, no stale out_valid after release.

Source files
------------

// File: rtl/mdu_iter_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes, FSM states
// and small op-class helpers.
package common;

  localparam int unsigned MDU_WIDTH_DEFAULT = 64;

  typedef enum logic [3:0] {
    MUL    = 4'd0,
    MULH   = 4'd1,
    MULHSU = 4'd2,
    MULHU  = 4'd3,
    DIV    = 4'd4,
    DIVU   = 4'd5,
    REM    = 4'd6,
    REMU   = 4'd7,
    MULW   = 4'd8,
    DIVW   = 4'd9,
    DIVUW  = 4'd10,
    REMW   = 4'd11,
    REMUW  = 4'd12
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  function automatic logic op_is_w(input md_op_t o);
    return o inside {MULW, DIVW, DIVUW, REMW, REMUW};
  endfunction

  function automatic logic op_is_div(input md_op_t o);
    return o inside {DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW};
  endfunction

  function automatic logic op_is_rem(input md_op_t o);
    return o inside {REM, REMU, REMW, REMUW};
  endfunction

endpackage

// File: rtl/mdu_iter_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract,
// keep or restore the partial remainder and emit one quotient bit.
module div_step #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    r_sh    = {rem, q[WIDTH-1]};
    diff    = r_sh - {1'b0, d};
    rem_nxt = diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    q_nxt   = {q[WIDTH-2:0], ~diff[WIDTH]};
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit: magnitudes are processed one bit per cycle,
// then a single FIX cycle applies sign, selects the half and registers the result.
module mdu_iter
  import common::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH_DEFAULT,
  parameter int unsigned EN_W  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam bit W_OK = (WIDTH == 64) && (EN_W != 0);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0] LAST_FULL = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_W    = CW'(31);

  mdu_state_t       state_q, state_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  md_op_t           op_q, op_nxt;
  logic             neg_q, neg_nxt;
  logic [WIDTH-1:0] hi_q, hi_nxt, lo_q, lo_nxt, opnd_q, opnd_nxt, result_q, result_nxt;
  logic             in_ready_q, out_valid_q;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] x);
    return x[31] ? -x : x;
  endfunction

  // Request decode: operand magnitudes, result sign, and the single-cycle special cases
  logic [31:0]      a32, b32;
  logic [WIDTH-1:0] a_w;
  logic             acc_fast, acc_neg;
  logic [WIDTH-1:0] acc_res, acc_lo, acc_opnd;

  always_comb begin
    a32      = a[31:0];
    b32      = b[31:0];
    a_w      = WIDTH'($signed(a32));
    acc_fast = 1'b0;
    acc_neg  = 1'b0;
    acc_res  = '0;
    acc_lo   = '0;
    acc_opnd = '0;
    case (op)
      MUL, MULHU: begin
        acc_opnd = a;
        acc_lo   = b;
      end
      MULH: begin
        acc_opnd = mag(a);
        acc_lo   = mag(b);
        acc_neg  = a[WIDTH-1] ^ b[WIDTH-1];
      end
      MULHSU: begin
        acc_opnd = mag(a);
        acc_lo   = b;
        acc_neg  = a[WIDTH-1];
      end
      MULW: begin
        acc_fast = !W_OK;
        acc_opnd = WIDTH'(a32);
        acc_lo   = WIDTH'(b32);
      end
      DIV, REM: begin
        if (b == '0) begin
          acc_fast = 1'b1;
          acc_res  = (op == DIV) ? '1 : a;
        end else if (a == MIN_NEG && b == '1) begin
          acc_fast = 1'b1;
          acc_res  = (op == DIV) ? a : '0;
        end
        acc_lo   = mag(a);
        acc_opnd = mag(b);
        acc_neg  = (op == DIV) ? (a[WIDTH-1] ^ b[WIDTH-1]) : a[WIDTH-1];
      end
      DIVU, REMU: begin
        acc_fast = (b == '0);
        acc_res  = (op == DIVU) ? '1 : a;
        acc_lo   = a;
        acc_opnd = b;
      end
      DIVW, REMW: begin
        if (!W_OK) begin
          acc_fast = 1'b1;
        end else if (b32 == '0) begin
          acc_fast = 1'b1;
          acc_res  = (op == DIVW) ? '1 : a_w;
        end else if (a32 == 32'h8000_0000 && b32 == '1) begin
          acc_fast = 1'b1;
          acc_res  = (op == DIVW) ? a_w : '0;
        end
        // Left-align the 32-bit dividend so 32 steps consume exactly its bits
        acc_lo   = WIDTH'(mag32(a32)) << 32;
        acc_opnd = WIDTH'(mag32(b32));
        acc_neg  = (op == DIVW) ? (a32[31] ^ b32[31]) : a32[31];
      end
      DIVUW, REMUW: begin
        if (!W_OK) begin
          acc_fast = 1'b1;
        end else if (b32 == '0) begin
          acc_fast = 1'b1;
          acc_res  = (op == DIVUW) ? '1 : a_w;
        end
        acc_lo   = WIDTH'(a32) << 32;
        acc_opnd = WIDTH'(b32);
      end
      default: acc_fast = 1'b1;
    endcase
  end

  // One iteration of either datapath
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] dv_rem, dv_q;

  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem     (hi_q),
    .q       (lo_q),
    .d       (opnd_q),
    .rem_nxt (dv_rem),
    .q_nxt   (dv_q)
  );

  // Final sign correction and half select
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   dval_s, fix_res;

  always_comb begin
    prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    dval_s = op_is_rem(op_q) ? hi_q : lo_q;
    dval_s = neg_q ? -dval_s : dval_s;
    case (op_q)
      MUL:                     fix_res = lo_q;
      MULH, MULHSU, MULHU:     fix_res = prod_s[2*WIDTH-1:WIDTH];
      MULW:                    fix_res = WIDTH'($signed(lo_q[WIDTH-1 -: 32]));
      DIV, DIVU, REM, REMU:    fix_res = dval_s;
      DIVW, DIVUW, REMW, REMUW: fix_res = WIDTH'($signed(dval_s[31:0]));
      default:                 fix_res = '0;
    endcase
  end

  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    op_nxt     = op_q;
    neg_nxt    = neg_q;
    hi_nxt     = hi_q;
    lo_nxt     = lo_q;
    opnd_nxt   = opnd_q;
    result_nxt = result_q;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            op_nxt   = op;
            neg_nxt  = acc_neg;
            hi_nxt   = '0;
            lo_nxt   = acc_lo;
            opnd_nxt = acc_opnd;
            cnt_nxt  = '0;
            if (acc_fast) begin
              result_nxt = acc_res;
              state_nxt  = DONE;
            end else begin
              state_nxt = BUSY;
            end
          end
        end
        BUSY: begin
          if (op_is_div(op_q)) begin
            hi_nxt = dv_rem;
            lo_nxt = dv_q;
          end else begin
            hi_nxt = mul_sum[WIDTH:1];
            lo_nxt = {mul_sum[0], lo_q[WIDTH-1:1]};
          end
          cnt_nxt = cnt_q + CW'(1);
          if (cnt_q == (op_is_w(op_q) ? LAST_W : LAST_FULL)) begin
            cnt_nxt   = '0;
            state_nxt = FIX;
          end
        end
        FIX: begin
          result_nxt = fix_res;
          state_nxt  = DONE;
        end
        DONE: if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= MUL;
      neg_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      op_q        <= op_nxt;
      neg_q       <= neg_nxt;
      hi_q        <= hi_nxt;
      lo_q        <= lo_nxt;
      opnd_q      <= opnd_nxt;
      result_q    <= result_nxt;
      in_ready_q  <= (state_nxt == IDLE);
      out_valid_q <= (state_nxt == DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed and randomized checks of mdu_iter (WIDTH=64, word ops enabled) against an
// arithmetic reference model.
module tb_mdu_iter;
  import common::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  md_op_t      op;
  logic [63:0] a, b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;

  int vectors    = 0;
  int miscompares = 0;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  mdu_iter #(.WIDTH(64), .EN_W(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Architectural result from plain arithmetic
  function automatic logic [63:0] model(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
    logic [127:0] p;
    longint       sx, sy;
    int           x32, y32;
    int unsigned  ux32, uy32;
    logic [31:0]  r32;
    logic [63:0]  r;
    sx = x; sy = y;
    x32 = x[31:0]; y32 = y[31:0];
    ux32 = x[31:0]; uy32 = y[31:0];
    r = '0;
    case (o)
      4'd0: r = x * y;
      4'd1: begin p = {{64{x[63]}}, x} * {{64{y[63]}}, y}; r = p[127:64]; end
      4'd2: begin p = {{64{x[63]}}, x} * {64'b0, y};       r = p[127:64]; end
      4'd3: begin p = {64'b0, x} * {64'b0, y};             r = p[127:64]; end
      4'd4: r = (y == 0) ? '1 : (x == MIN64 && y == '1) ? x : 64'(sx / sy);
      4'd5: r = (y == 0) ? '1 : x / y;
      4'd6: r = (y == 0) ? x : (x == MIN64 && y == '1) ? 64'd0 : 64'(sx % sy);
      4'd7: r = (y == 0) ? x : x % y;
      4'd8: begin r32 = x[31:0] * y[31:0]; r = sext32(r32); end
      4'd9: begin
        if (y32 == 0) r = '1;
        else if (x[31:0] == 32'h8000_0000 && y32 == -1) r = sext32(x[31:0]);
        else begin r32 = 32'(x32 / y32); r = sext32(r32); end
      end
      4'd10: begin
        if (uy32 == 0) r = '1;
        else begin r32 = ux32 / uy32; r = sext32(r32); end
      end
      4'd11: begin
        if (y32 == 0) r = sext32(x[31:0]);
        else if (x[31:0] == 32'h8000_0000 && y32 == -1) r = '0;
        else begin r32 = 32'(x32 % y32); r = sext32(r32); end
      end
      4'd12: begin
        if (uy32 == 0) r = sext32(x[31:0]);
        else begin r32 = ux32 % uy32; r = sext32(r32); end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Edges after the accepting edge until out_valid is seen; special cases are visible
  // in the cycle that directly follows the accepting edge.
  function automatic int exp_lat(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
    bit fast;
    fast = 1'b0;
    if (o > 4'd12) fast = 1'b1;
    else if (o inside {4'd4, 4'd5, 4'd6, 4'd7}) fast = (y == 0) || ((o == 4'd4 || o == 4'd6) && x == MIN64 && y == '1);
    else if (o inside {4'd9, 4'd10, 4'd11, 4'd12})
      fast = (y[31:0] == 0) || ((o == 4'd9 || o == 4'd11) && x[31:0] == 32'h8000_0000 && y[31:0] == '1);
    if (fast) return 0;
    return (o >= 4'd8) ? 33 : 65;
  endfunction

  function automatic logic [63:0] rnd_opnd();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return '1;
      2: return MIN64;
      3: return 64'($urandom_range(0, 20));
      4: return sext32($urandom_range(0, 3) == 0 ? 32'h8000_0000 : $urandom);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic accept_req(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
    int w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    op = md_op_t'(o); a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    op = md_op_t'(4'($urandom_range(0, 15)));
  endtask

  task automatic run_op(input string tag, input logic [3:0] o, input logic [63:0] x,
                        input logic [63:0] y, input int hold);
    logic [63:0] exp;
    int lat;
    exp = model(o, x, y);
    accept_req(o, x, y);
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat(o, x, y)));
    chk({tag, "_res"}, result, exp);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_res"}, result, exp);
      chk({tag, "_hold_rdy"}, {63'b0, in_ready, out_valid}, 64'b01);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drain"}, 64'(out_valid), 64'd0);
  endtask

  task automatic no_valid_for(input string tag, input int cycles);
    logic seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin @(posedge clk); #1; seen |= out_valid; end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    op = MUL; a = '0; b = '0;
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    #19 reset_n = 1'b1;
    #1 chk("rel_in_ready_pre", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    run_op("mul_3_m5", 4'd0, 64'd3, -64'sd5, 0);
    run_op("div_m7_2", 4'd4, -64'sd7, 64'd2, 0);
    run_op("rem_m7_2", 4'd6, -64'sd7, 64'd2, 0);
    run_op("divu_by0", 4'd5, 64'd42, 64'd0, 0);
    run_op("rem_by0", 4'd6, 64'd42, 64'd0, 0);
    run_op("div_ovf", 4'd4, MIN64, '1, 0);
    run_op("mulw", 4'd8, 64'h7FFF_FFFF, 64'd2, 0);
    run_op("mulhu_ones", 4'd3, '1, '1, 0);
    run_op("divuw_neg", 4'd10, 64'hFFFF_FFFF, 64'd1, 0);
    run_op("illegal", 4'd14, 64'd5, 64'd6, 0);

    // Abort mid-iteration, then verify the unit is usable again
    accept_req(4'd4, 64'd1000, 64'd7);
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle", {63'b0, in_ready, out_valid}, 64'b10);
    no_valid_for("flush_no_valid", 80);
    run_op("after_flush", 4'd4, 64'd1000, 64'd7, 0);

    // Flush beats a simultaneous request
    op = MUL; a = 64'd2; b = 64'd3; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_vs_accept", 64'(in_ready), 64'd1);
    no_valid_for("flush_vs_accept_nv", 80);

    run_op("hold5", 4'd1, -64'sd12345, 64'd987654321, 5);

    // Reset in the middle of an operation
    accept_req(4'd0, 64'd77, 64'd99);
    repeat (20) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    chk("midrst_outs", {in_ready, out_valid, result}, 66'd0);
    #10 reset_n = 1'b1;
    no_valid_for("midrst_no_valid", 80);
    chk("midrst_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd(),
             ($urandom_range(0, 7) == 0) ? 2 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
